// File: rtl/sprite_pkg.sv
// Shared constants and loader state type for the sprite bitmap store.
package sprite_pkg;

  localparam int unsigned SPRITE_SIZE = 16;
  localparam int unsigned FRAME_COUNT = 2;
  localparam int unsigned FRAME_W     = $clog2(FRAME_COUNT);
  localparam int unsigned ROW_W       = $clog2(SPRITE_SIZE);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } load_state_e;

endpackage

// File: rtl/sprite_row_ram.sv
// Bitmap row storage: one synchronous write port, one synchronous read port.
module sprite_row_ram #(
  parameter int unsigned WORDS = 32,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AW = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [WORDS];

  // Contents are deliberately not reset; readers rely on frame_valid to mask stale rows.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sprite_bitmap_store.sv
// Multi-frame 16x16 sprite bitmap with a row-streaming loader and a 1-cycle pixel read.
module sprite_bitmap_store #(
  parameter int unsigned FRAME_COUNT = sprite_pkg::FRAME_COUNT,
  parameter int unsigned SPRITE_SIZE = sprite_pkg::SPRITE_SIZE,
  localparam int unsigned FW = $clog2(FRAME_COUNT),
  localparam int unsigned RW = $clog2(SPRITE_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [FW-1:0]          animState,
  input  logic [RW-1:0]          yin,
  input  logic [RW-1:0]          xin,
  output logic                   out,
  input  logic                   load_start,
  input  logic [FW-1:0]          load_frame,
  input  logic                   load_valid,
  input  logic [SPRITE_SIZE-1:0] load_data,
  output logic                   load_ready,
  output logic                   load_done,
  output logic [FRAME_COUNT-1:0] frame_valid
);

  import sprite_pkg::*;

  localparam logic [RW-1:0] LastRow = RW'(SPRITE_SIZE - 1);

  load_state_e            state_q, state_d;
  logic [RW-1:0]          row_q, row_d;
  logic [FW-1:0]          frame_q, frame_d;
  logic [FRAME_COUNT-1:0] valid_q, valid_d;
  logic                   wr_en;
  logic [SPRITE_SIZE-1:0] rd_row;
  logic [RW-1:0]          xin_q;
  logic                   pix_en_q;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    frame_d    = frame_q;
    valid_d    = valid_q;
    wr_en      = 1'b0;
    load_ready = 1'b0;
    load_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          frame_d             = load_frame;
          valid_d[load_frame] = 1'b0;
          row_d               = '0;
          state_d             = StLoad;
        end
      end
      StLoad: begin
        load_ready = 1'b1;
        if (load_valid) begin
          wr_en = 1'b1;
          // Last row ends the load instead of wrapping into another write.
          if (row_q == LastRow) begin
            state_d = StDone;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      StDone: begin
        load_done        = 1'b1;
        valid_d[frame_q] = 1'b1;
        state_d          = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      row_q    <= '0;
      frame_q  <= '0;
      valid_q  <= '0;
      xin_q    <= '0;
      pix_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      frame_q  <= frame_d;
      valid_q  <= valid_d;
      xin_q    <= xin;
      pix_en_q <= valid_q[animState];
    end
  end

  sprite_row_ram #(
    .WORDS(FRAME_COUNT * SPRITE_SIZE),
    .WIDTH(SPRITE_SIZE)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr({frame_q, row_q}),
    .wdata(load_data),
    .raddr({animState, yin}),
    .rdata(rd_row)
  );

  // Row, column and valid are all captured on the same edge; bit select keeps 1-cycle latency.
  assign out         = pix_en_q & rd_row[LastRow - xin_q];
  assign frame_valid = valid_q;

endmodule

// File: tb/tb_sprite_bitmap_store.sv
// Randomized self-checking bench for sprite_bitmap_store against a frame/row array model.
module tb_sprite_bitmap_store;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:0]  animState;
  logic [3:0]  yin;
  logic [3:0]  xin;
  logic        out;
  logic        load_start;
  logic [0:0]  load_frame;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic [1:0]  frame_valid;

  sprite_bitmap_store dut (
    .clk        (clk),
    .reset      (reset),
    .animState  (animState),
    .yin        (yin),
    .xin        (xin),
    .out        (out),
    .load_start (load_start),
    .load_frame (load_frame),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  // Reference model: bitmap array, valid flags, and loader phase (0 idle, 1 loading, 2 done).
  logic [15:0] mmem [2][16];
  logic [1:0]  mvalid;
  int          mode;
  int          mframe;
  int          mrows;

  logic exp_out, exp_ready, exp_done, obs_ready, obs_done;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void model_reset();
    mode    = 0;
    mrows   = 0;
    mvalid  = 2'b00;
    exp_out = 1'b0;
  endfunction

  // Advance one clock, applying the specified rules to the model.
  task automatic tick();
    logic nxt;
    exp_ready = (mode == 1);
    exp_done  = (mode == 2);
    obs_ready = load_ready;
    obs_done  = load_done;
    nxt = mvalid[animState] ? mmem[animState][yin][4'd15 - xin] : 1'b0;
    case (mode)
      0: if (load_start) begin
        mframe         = int'(load_frame);
        mvalid[mframe] = 1'b0;
        mrows          = 0;
        mode           = 1;
      end
      1: if (load_valid) begin
        mmem[mframe][mrows] = load_data;
        mrows++;
        if (mrows == 16) mode = 2;
      end
      default: begin
        mvalid[mframe] = 1'b1;
        mode           = 0;
      end
    endcase
    @(posedge clk);
    #1;
    exp_out = nxt;
  endtask

  task automatic rand_read();
    animState = 1'($urandom_range(0, 1));
    yin       = 4'($urandom);
    xin       = 4'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_vec++; if (out !== 1'b0) begin n_err++; $display("FAIL reset_out: got %b want 0", out); end
    n_vec++; if (frame_valid !== 2'b00) begin
      n_err++; $display("FAIL reset_frame_valid: got %b want 00", frame_valid);
    end
    n_vec++; if (load_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready: got %b want 0", load_ready);
    end
    n_vec++; if (load_done !== 1'b0) begin
      n_err++; $display("FAIL reset_done: got %b want 0", load_done);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      rand_read();
      tick();
      n_vec++; if (out !== 1'b0) begin n_err++; $display("FAIL reset_read: got %b want 0", out); end
    end
  endtask

  task automatic test_pattern();
    int nrdy = 0;
    int ndone = 0;
    int guard = 0;
    bit fin = 0;
    animState = 1'b0; yin = 4'd0; xin = 4'd0;
    load_frame = 1'b1; load_start = 1'b1;
    tick();
    load_start = 1'b0; load_valid = 1'b1;
    while (!fin && guard < 40) begin
      load_data = 16'(16'h8000 >> nrdy);
      tick();
      guard++;
      n_vec++; if (obs_ready !== exp_ready) begin
        n_err++; $display("FAIL pattern_ready: got %b want %b", obs_ready, exp_ready);
      end
      n_vec++; if (out !== exp_out) begin
        n_err++; $display("FAIL pattern_out_load: got %b want %b", out, exp_out);
      end
      if (obs_ready) nrdy++;
      if (obs_done) begin ndone++; fin = 1; end
    end
    load_valid = 1'b0;
    n_vec++; if (!fin) begin n_err++; $display("FAIL pattern_timeout: got no load_done want load_done"); end
    n_vec++; if (nrdy != 16) begin n_err++; $display("FAIL pattern_ready_count: got %0d want 16", nrdy); end
    n_vec++; if (frame_valid !== 2'b10) begin
      n_err++; $display("FAIL pattern_frame_valid: got %b want 10", frame_valid);
    end
    animState = 1'b1; yin = 4'd0; xin = 4'd0; tick();
    n_vec++; if (out !== 1'b1) begin n_err++; $display("FAIL pattern_y0x0: got %b want 1", out); end
    yin = 4'd15; xin = 4'd15; tick();
    n_vec++; if (out !== 1'b1) begin n_err++; $display("FAIL pattern_y15x15: got %b want 1", out); end
    yin = 4'd0; xin = 4'd1; tick();
    n_vec++; if (out !== 1'b0) begin n_err++; $display("FAIL pattern_y0x1: got %b want 0", out); end
  endtask

  task automatic test_toggle_valid();
    logic [15:0] sent [16];
    int nx = 0;
    int guard = 0;
    bit fin = 0;
    load_frame = 1'b0; load_start = 1'b1; rand_read();
    tick();
    load_start = 1'b0; load_valid = 1'b0;
    while (!fin && guard < 60) begin
      load_valid = ~load_valid;
      load_data  = 16'($urandom);
      rand_read();
      if (load_ready && load_valid && nx < 16) begin sent[nx] = load_data; nx++; end
      tick();
      guard++;
      n_vec++; if (obs_ready !== exp_ready || obs_done !== exp_done) begin
        n_err++; $display("FAIL toggle_handshake: got rdy=%b done=%b want rdy=%b done=%b",
                          obs_ready, obs_done, exp_ready, exp_done);
      end
      n_vec++; if (out !== exp_out) begin
        n_err++; $display("FAIL toggle_out: got %b want %b", out, exp_out);
      end
      if (obs_done) begin
        fin = 1;
        n_vec++; if (nx != 16) begin
          n_err++; $display("FAIL toggle_done_early: got %0d rows want 16", nx);
        end
      end
    end
    load_valid = 1'b0;
    n_vec++; if (!fin) begin n_err++; $display("FAIL toggle_timeout: got no load_done want load_done"); end
    n_vec++; if (frame_valid !== mvalid) begin
      n_err++; $display("FAIL toggle_frame_valid: got %b want %b", frame_valid, mvalid);
    end
    for (int r = 0; r < 16; r++) begin
      logic want;
      animState = 1'b0; yin = 4'(r); xin = 4'($urandom);
      want = sent[r][4'd15 - xin];
      tick();
      n_vec++; if (out !== want) begin
        n_err++; $display("FAIL toggle_row_order: row %0d got %b want %b", r, out, want);
      end
    end
  endtask

  task automatic test_ignore_start();
    int guard = 0;
    bit fin = 0;
    load_frame = 1'b1; load_start = 1'b1; rand_read();
    tick();
    load_start = 1'b0; load_valid = 1'b1;
    while (!fin && guard < 40) begin
      load_start = (guard == 5 || guard == 16);
      load_frame = 1'b0;
      load_data  = 16'($urandom);
      rand_read();
      tick();
      guard++;
      n_vec++; if (frame_valid !== mvalid || out !== exp_out) begin
        n_err++; $display("FAIL ignore_state: got fv=%b out=%b want fv=%b out=%b",
                          frame_valid, out, mvalid, exp_out);
      end
      if (obs_done) fin = 1;
    end
    load_start = 1'b0; load_valid = 1'b0;
    n_vec++; if (!fin) begin n_err++; $display("FAIL ignore_timeout: got no load_done want load_done"); end
    n_vec++; if (frame_valid !== 2'b11) begin
      n_err++; $display("FAIL ignore_frame_valid: got %b want 11", frame_valid);
    end
    n_vec++; if (load_ready !== 1'b0) begin
      n_err++; $display("FAIL ignore_idle_ready: got %b want 0", load_ready);
    end
  endtask

  task automatic test_reload_while_reading();
    int guard = 0;
    bit fin = 0;
    load_frame = 1'b1; load_start = 1'b1; rand_read();
    tick();
    load_start = 1'b0; load_valid = 1'b1; load_data = 16'hffff;
    while (!fin && guard < 40) begin
      rand_read();
      tick();
      guard++;
      n_vec++; if (out !== exp_out) begin
        n_err++; $display("FAIL reload_out: frame %0d got %b want %b", animState, out, exp_out);
      end
      if (obs_done) fin = 1;
    end
    load_valid = 1'b0;
    n_vec++; if (!fin) begin n_err++; $display("FAIL reload_timeout: got no load_done want load_done"); end
    for (int i = 0; i < 4; i++) begin
      animState = 1'b1; yin = 4'($urandom); xin = 4'($urandom);
      tick();
      n_vec++; if (out !== 1'b1) begin n_err++; $display("FAIL reload_after: got %b want 1", out); end
      animState = 1'b0;
      tick();
      n_vec++; if (out !== exp_out) begin
        n_err++; $display("FAIL reload_frame0: got %b want %b", out, exp_out);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    load_frame = 1'b0; load_start = 1'b1;
    tick();
    load_start = 1'b0; load_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load_data = 16'($urandom);
      tick();
    end
    reset = 1'b1;
    #1;
    n_vec++; if (frame_valid !== 2'b00 || load_ready !== 1'b0 || out !== 1'b0) begin
      n_err++; $display("FAIL midreset_state: got fv=%b rdy=%b out=%b want fv=00 rdy=0 out=0",
                        frame_valid, load_ready, out);
    end
    @(posedge clk); #1;
    reset = 1'b0; load_valid = 1'b0;
    model_reset();
    load_frame = 1'b0; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    n_vec++; if (load_ready !== 1'b1) begin
      n_err++; $display("FAIL midreset_restart: got %b want 1", load_ready);
    end
    load_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      load_data = 16'($urandom);
      animState = 1'b1; yin = 4'($urandom); xin = 4'($urandom);
      tick();
      n_vec++; if (out !== exp_out || frame_valid !== mvalid) begin
        n_err++; $display("FAIL midreset_stale: got out=%b fv=%b want out=%b fv=%b",
                          out, frame_valid, exp_out, mvalid);
      end
    end
    load_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      animState = 1'b0; yin = 4'($urandom); xin = 4'($urandom);
      tick();
      n_vec++; if (out !== exp_out) begin
        n_err++; $display("FAIL midreset_reload: got %b want %b", out, exp_out);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load_start = ($urandom_range(0, 7) == 0);
      load_frame = 1'($urandom_range(0, 1));
      load_valid = 1'($urandom_range(0, 1));
      load_data  = 16'($urandom);
      rand_read();
      tick();
      n_vec++; if (out !== exp_out || frame_valid !== mvalid || obs_ready !== exp_ready ||
                   obs_done !== exp_done) begin
        n_err++; $display("FAIL random_%0d: got out=%b fv=%b rdy=%b done=%b want %b %b %b %b", i,
                          out, frame_valid, obs_ready, obs_done, exp_out, mvalid, exp_ready,
                          exp_done);
      end
    end
    load_start = 1'b0; load_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    animState = 1'b0; yin = 4'd0; xin = 4'd0;
    load_start = 1'b0; load_frame = 1'b0; load_valid = 1'b0; load_data = 16'h0;
    for (int f = 0; f < 2; f++) for (int r = 0; r < 16; r++) mmem[f][r] = 16'h0;
    model_reset();
    test_reset();
    test_pattern();
    test_toggle_valid();
    test_ignore_start();
    test_reload_while_reading();
    test_reset_mid_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
